// File: rtl/utils.sv
// Shared bench-utility types: the test statistics word, the scoreboard state
// encoding and a saturating 32-bit adder used by the result counters.
package utils;

  typedef struct packed {
    logic [31:0] pass_cnt;
    logic [31:0] fail_cnt;
  } test_stats;

  typedef enum logic [1:0] {
    SCB_IDLE  = 2'd0,
    SCB_RUN   = 2'd1,
    SCB_DRAIN = 2'd2,
    SCB_DONE  = 2'd3
  } scb_state_e;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum_v;
    sum_v = {1'b0, a} + {1'b0, b};
    return sum_v[32] ? 32'hFFFF_FFFF : sum_v[31:0];
  endfunction

endpackage

// File: rtl/scb_fifo.sv
// Synchronous FIFO holding expected words; one-bit-wider pointers give
// full/empty, and a read is never visible in the same cycle as its write.
module scb_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic              do_push_s;
  logic              do_pop_s;

  // a pop frees the slot, so a simultaneous push is legal even when full
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  assign count = wr_ptr_r - rd_ptr_r;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign dout  = mem_r[rd_ptr_r[AW-1:0]];

  // pointer registers with synchronous reset and flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // storage array write port
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end

endmodule

// File: rtl/stream_scoreboard.sv
// In-order scoreboard: queues expected words, compares them against actual
// words, keeps saturating pass/fail counts and captures the first failure.
module stream_scoreboard
  import utils::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              act_valid,
  output logic              act_ready,
  input  logic [DATA_W-1:0] act_data,
  output test_stats         stats,
  output logic              mismatch,
  output logic [31:0]       first_fail_idx,
  output logic [DATA_W-1:0] first_fail_exp,
  output logic [DATA_W-1:0] first_fail_act,
  output logic              busy,
  output logic              done,
  output logic              timed_out
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  scb_state_e        state_r, next_state_s;
  logic              push_s, pop_s, full_s, empty_s;
  logic [DATA_W-1:0] head_s;
  logic [CW-1:0]     count_s;
  logic              start_clr_s, drain_end_s, timeout_s;
  logic [TW-1:0]     idle_cnt_r;
  logic              cmp_valid_r, cmp_eq_r;
  logic [DATA_W-1:0] cmp_exp_r, cmp_act_r;
  logic [31:0]       pass_cnt_r, fail_cnt_r, cmp_idx_r, fail_add_s;
  logic              fail_seen_r, mismatch_r, timed_out_r;
  logic [31:0]       ff_idx_r;
  logic [DATA_W-1:0] ff_exp_r, ff_act_r;

  assign exp_ready   = (state_r == SCB_RUN) & ~full_s;
  assign act_ready   = ((state_r == SCB_RUN) | (state_r == SCB_DRAIN)) & ~empty_s;
  assign push_s      = exp_valid & exp_ready;
  assign pop_s       = act_valid & act_ready;
  assign start_clr_s = start & ((state_r == SCB_IDLE) | (state_r == SCB_DONE));
  assign drain_end_s = (state_r == SCB_DRAIN) & empty_s & ~cmp_valid_r;
  assign timeout_s   = (state_r == SCB_DRAIN) & ~drain_end_s & ~pop_s &
                       (idle_cnt_r == TW'(TIMEOUT - 1));
  // a timeout charges every still-queued word as a failure
  assign fail_add_s  = ((cmp_valid_r & ~cmp_eq_r) ? 32'd1 : 32'd0) +
                       (timeout_s ? 32'(count_s) : 32'd0);

  scb_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .flush (timeout_s),
    .din   (exp_data),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= SCB_IDLE;
    else        state_r <= next_state_s;
  end

  // next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      SCB_IDLE:  if (start) next_state_s = SCB_RUN;  else next_state_s = SCB_IDLE;
      SCB_RUN:   if (finish) next_state_s = SCB_DRAIN; else next_state_s = SCB_RUN;
      SCB_DRAIN: if (drain_end_s | timeout_s) next_state_s = SCB_DONE;
                 else next_state_s = SCB_DRAIN;
      SCB_DONE:  if (start) next_state_s = SCB_RUN;  else next_state_s = SCB_DONE;
      default:   next_state_s = SCB_IDLE;
    endcase
  end

  // compare stage: pop the head and register the equality result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmp_valid_r <= 1'b0;
      cmp_eq_r    <= 1'b0;
      cmp_exp_r   <= '0;
      cmp_act_r   <= '0;
    end else begin
      cmp_valid_r <= pop_s;
      if (pop_s) begin
        cmp_eq_r  <= (head_s == act_data);
        cmp_exp_r <= head_s;
        cmp_act_r <= act_data;
      end
    end
  end

  // DRAIN idle timer, restarted by every actual-word handshake
  always_ff @(posedge clk) begin
    if (!rst_n || start_clr_s) begin
      idle_cnt_r <= '0;
    end else if (state_r == SCB_DRAIN) begin
      if (pop_s) idle_cnt_r <= '0;
      else       idle_cnt_r <= idle_cnt_r + TW'(1);
    end
  end

  // result counters, mismatch pulse and first-failure capture
  always_ff @(posedge clk) begin
    if (!rst_n || start_clr_s) begin
      pass_cnt_r  <= 32'd0;
      fail_cnt_r  <= 32'd0;
      cmp_idx_r   <= 32'd0;
      fail_seen_r <= 1'b0;
      mismatch_r  <= 1'b0;
      timed_out_r <= 1'b0;
      ff_idx_r    <= 32'd0;
      ff_exp_r    <= '0;
      ff_act_r    <= '0;
    end else begin
      mismatch_r <= cmp_valid_r & ~cmp_eq_r;
      fail_cnt_r <= sat_add32(fail_cnt_r, fail_add_s);
      if (cmp_valid_r) begin
        cmp_idx_r <= sat_add32(cmp_idx_r, 32'd1);
        if (cmp_eq_r) begin
          pass_cnt_r <= sat_add32(pass_cnt_r, 32'd1);
        end else if (!fail_seen_r) begin
          fail_seen_r <= 1'b1;
          ff_idx_r    <= cmp_idx_r;
          ff_exp_r    <= cmp_exp_r;
          ff_act_r    <= cmp_act_r;
        end
      end
      if (timeout_s) timed_out_r <= 1'b1;
    end
  end

  assign stats          = {pass_cnt_r, fail_cnt_r};
  assign mismatch       = mismatch_r;
  assign first_fail_idx = ff_idx_r;
  assign first_fail_exp = ff_exp_r;
  assign first_fail_act = ff_act_r;
  assign timed_out      = timed_out_r;
  assign busy           = (state_r == SCB_RUN) | (state_r == SCB_DRAIN);
  assign done           = (state_r == SCB_DONE);

endmodule

// File: tb/tb_stream_scoreboard.sv
// Directed bench: stimulus queues expected end-of-test results and mismatch
// events; a monitor checks them when done rises or mismatch pulses.
module tb_stream_scoreboard;
  import utils::*;

  logic        clk = 1'b0;
  logic        rst_n, start, finish, exp_valid, act_valid;
  logic        exp_ready, act_ready, mismatch, busy, done, timed_out;
  logic [31:0] exp_data, act_data, first_fail_idx, first_fail_exp, first_fail_act;
  test_stats   stats;

  stream_scoreboard #(.DATA_W(32), .DEPTH(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .stats(stats), .mismatch(mismatch), .first_fail_idx(first_fail_idx),
    .first_fail_exp(first_fail_exp), .first_fail_act(first_fail_act),
    .busy(busy), .done(done), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pass_cnt, fail_cnt, ff_idx, ff_exp, ff_act;
    logic        to;
  } res_t;

  res_t        res_q[$];
  logic [31:0] mm_q[$];
  logic [31:0] exp_words[$], act_words[$];
  int          push_cyc[$], pop_cyc[$];
  int          both_cnt, blocked_cyc;
  int          n_checks = 0, n_err = 0;
  logic        done_q = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // monitor: mismatch pulses and end-of-test results against the queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (mismatch) begin
        if (mm_q.size() == 0) check("unexpected_mismatch", 64'd1, 64'd0);
        else check("mismatch_fail_cnt", 64'(stats.fail_cnt), 64'(mm_q.pop_front()));
      end
      if (done && !done_q) begin
        if (res_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          res_t r;
          r = res_q.pop_front();
          check({r.name, "_pass"},      64'(stats.pass_cnt), 64'(r.pass_cnt));
          check({r.name, "_fail"},      64'(stats.fail_cnt), 64'(r.fail_cnt));
          check({r.name, "_timed_out"}, 64'(timed_out),      64'(r.to));
          check({r.name, "_ff_idx"},    64'(first_fail_idx), 64'(r.ff_idx));
          check({r.name, "_ff_exp"},    64'(first_fail_exp), 64'(r.ff_exp));
          check({r.name, "_ff_act"},    64'(first_fail_act), 64'(r.ff_act));
        end
      end
    end
    done_q <= done;
  end

  task automatic expect_result(input string name, input logic [31:0] p, input logic [31:0] f,
                               input logic to, input logic [31:0] idx, input logic [31:0] e,
                               input logic [31:0] a);
    res_t r;
    r.name = name; r.pass_cnt = p; r.fail_cnt = f; r.to = to;
    r.ff_idx = idx; r.ff_exp = e; r.ff_act = a;
    res_q.push_back(r);
  endtask

  // all tasks start and end at a falling edge
  task automatic pulse_start();
    start = 1'b1; @(posedge clk); @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1; @(posedge clk); @(negedge clk); finish = 1'b0;
  endtask

  task automatic run_streams(input int act_start, input int budget);
    int cyc = 0;
    logic hs_e, hs_a;
    push_cyc.delete(); pop_cyc.delete(); both_cnt = 0; blocked_cyc = -1;
    while ((exp_words.size() > 0 || act_words.size() > 0) && cyc < budget) begin
      exp_valid = (exp_words.size() > 0);
      exp_data  = exp_valid ? exp_words[0] : 32'd0;
      act_valid = (act_words.size() > 0) && (cyc >= act_start);
      act_data  = act_valid ? act_words[0] : 32'd0;
      hs_e = exp_valid & exp_ready;
      hs_a = act_valid & act_ready;
      if (exp_valid && !exp_ready && blocked_cyc < 0) blocked_cyc = cyc;
      @(posedge clk);
      if (hs_e) begin void'(exp_words.pop_front()); push_cyc.push_back(cyc); end
      if (hs_a) begin void'(act_words.pop_front()); pop_cyc.push_back(cyc); end
      if (hs_e && hs_a) both_cnt++;
      cyc++;
      @(negedge clk);
    end
    exp_valid = 1'b0; act_valid = 1'b0;
    if (cyc >= budget) check("stream_budget", 64'd1, 64'd0);
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); @(negedge clk); cycles++;
    end while (!done && cycles < budget);
    if (!done) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic case1(input string name);
    int cyc;
    expect_result(name, 32'd8, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    pulse_start();
    check({name, "_busy"}, 64'(busy), 64'd1);
    for (int i = 0; i < 8; i++) exp_words.push_back(32'(i));
    for (int i = 0; i < 8; i++) act_words.push_back(32'(i));
    run_streams(2, 200);
    pulse_finish();
    wait_done(20, cyc);
    check({name, "_done_within_2"}, 64'((cyc + 1) <= 2), 64'd1);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; finish = 1'b0;
    exp_valid = 1'b0; act_valid = 1'b0; exp_data = 32'd0; act_data = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stats", 64'(stats), 64'd0);
    check("rst_flags", 64'({exp_ready, act_ready, mismatch, busy, done, timed_out}), 64'd0);
    check("rst_ff", 64'(first_fail_idx | first_fail_exp | first_fail_act), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: clean in-order match
    case1("c1");

    // 2: single mismatch at index 3
    expect_result("c2", 32'd4, 32'd1, 1'b0, 32'd3, 32'd13, 32'd99);
    mm_q.push_back(32'd1);
    pulse_start();
    exp_words = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd14};
    act_words = '{32'd10, 32'd11, 32'd12, 32'd99, 32'd14};
    run_streams(0, 200);
    pulse_finish();
    wait_done(20, cyc);

    // 3: backpressure on a full queue
    expect_result("c3", 32'd17, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    pulse_start();
    for (int i = 0; i < 17; i++) begin
      exp_words.push_back(32'(100 + i));
      act_words.push_back(32'(100 + i));
    end
    run_streams(20, 300);
    check("c3_16th_push_cyc", 64'(push_cyc[15]), 64'd15);
    check("c3_blocked_cyc", 64'(blocked_cyc), 64'd16);
    check("c3_first_pop_cyc", 64'(pop_cyc[0]), 64'd20);
    check("c3_17th_push_cyc", 64'(push_cyc[16]), 64'(pop_cyc[0] + 1));
    pulse_finish();
    wait_done(20, cyc);

    // 4: drain timeout with 3 words left
    expect_result("c4", 32'd0, 32'd3, 1'b1, 32'd0, 32'd0, 32'd0);
    pulse_start();
    exp_words = '{32'd7, 32'd8, 32'd9};
    run_streams(0, 50);
    pulse_finish();
    wait_done(50, cyc);
    check("c4_drain_cycles", 64'(cyc), 64'd8);

    // 5: back-to-back stream of 100 words
    expect_result("c5", 32'd100, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      exp_words.push_back(32'h5A00_0000 + 32'(i));
      act_words.push_back(32'h5A00_0000 + 32'(i));
    end
    run_streams(0, 400);
    check("c5_push_pop_same_cycle", 64'(both_cnt), 64'd99);
    pulse_finish();
    wait_done(20, cyc);

    // 6: reset in DRAIN with 5 queued, then rerun case 1
    pulse_start();
    for (int i = 0; i < 5; i++) exp_words.push_back(32'(i));
    run_streams(0, 50);
    pulse_finish();
    check("c6_in_drain", 64'({busy, act_ready, done}), 64'b110);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0; @(posedge clk); @(negedge clk); rst_n = 1'b1;
    check("c6_rst_stats", 64'(stats), 64'd0);
    check("c6_rst_flags", 64'({exp_ready, act_ready, busy, done, timed_out}), 64'd0);
    @(negedge clk);
    case1("c6_rerun");

    repeat (3) @(negedge clk);
    check("res_q_drained", 64'(res_q.size()), 64'd0);
    check("mm_q_drained", 64'(mm_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
